// File: rtl/xc_malu_div.sv
// Iterative 32-bit restoring divider: one quotient bit per cycle, fixed latency.
// Signed operands are reduced to magnitudes and the result sign is fixed up once, when the operation completes.
module xc_malu_div (
  input  logic        clock,
  input  logic        resetn,
  input  logic        valid,
  input  logic        flush,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        op_signed,
  input  logic        op_rem,
  output logic        busy,
  output logic        ready,
  output logic [31:0] result
);
  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;       // original dividend, kept for divide-by-zero remainder
  logic [31:0] b_q, b_d;       // divisor, magnitude after SETUP
  logic [31:0] q_q, q_d;       // dividend shifts out of the top, quotient bits shift in
  logic [31:0] r_q, r_d;
  logic        sgn_q, sgn_d, rem_q, rem_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic [31:0] result_q, result_d;

  logic [32:0] tmp;
  logic [33:0] diff;
  logic [31:0] q_fix, r_fix, final_val;

  always_comb begin
    tmp  = {r_q, q_q[31]};
    diff = {1'b0, tmp} - {2'b00, b_q};
    q_fix = qneg_q ? (~q_q + 32'd1) : q_q;
    r_fix = rneg_q ? (~r_q + 32'd1) : r_q;
    // Zero divisor bypasses sign correction entirely.
    if (b_q == 32'd0) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = a_q;
    end
    final_val = rem_q ? r_fix : q_fix;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    q_d      = q_q;
    r_d      = r_q;
    sgn_d    = sgn_q;
    rem_d    = rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = SETUP;
        a_d     = rs1;
        b_d     = rs2;
        sgn_d   = op_signed;
        rem_d   = op_rem;
      end
      SETUP: begin
        q_d     = (sgn_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
        b_d     = (sgn_q && b_q[31]) ? (~b_q + 32'd1) : b_q;
        qneg_d  = sgn_q & (a_q[31] ^ b_q[31]);
        rneg_d  = sgn_q & a_q[31];
        r_d     = 32'd0;
        cnt_d   = 6'd0;
        state_d = RUN;
      end
      RUN: begin
        r_d   = diff[33] ? tmp[31:0] : diff[31:0];
        q_d   = {q_q[30:0], ~diff[33]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE: begin
        result_d = final_val;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      q_q      <= 32'd0;
      r_q      <= 32'd0;
      sgn_q    <= 1'b0;
      rem_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      q_q      <= q_d;
      r_q      <= r_d;
      sgn_q    <= sgn_d;
      rem_q    <= rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == SETUP) || (state_q == RUN);
  assign ready  = (state_q == DONE) && !flush;
  assign result = ready ? final_val : result_q;
endmodule

// File: tb/tb_xc_malu_div.sv
// Directed-vector and randomised bench for xc_malu_div: results, fixed latency, flush and reset.
module tb_xc_malu_div;
  logic        clock = 1'b0;
  logic        resetn, valid, flush, op_signed, op_rem;
  logic [31:0] rs1, rs2;
  logic        busy, ready;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int rdy_cnt = 0;

  xc_malu_div dut (
    .clock(clock), .resetn(resetn), .valid(valid), .flush(flush),
    .rs1(rs1), .rs2(rs2), .op_signed(op_signed), .op_rem(op_rem),
    .busy(busy), .ready(ready), .result(result)
  );

  always #5 clock = ~clock;
  always @(negedge clock) if (ready) rdy_cnt++;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        r;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called just after the accept edge; lat = edge number at which ready is seen.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clock);
      lat++;
      if (ready) break;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic r,
                        output logic [31:0] res, output int lat);
    @(negedge clock);
    rs1 = a; rs2 = b; op_signed = s; op_rem = r; valid = 1'b1;
    @(posedge clock);
    #1 valid = 1'b0;
    wait_ready(lat);
    res = result;
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic r);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
      return r ? sa % sb : sa / sb;
    end
    return r ? a % b : a / b;
  endfunction

  initial begin
    logic [31:0] res, last_res, a, b;
    logic        s, r;
    int          lat, r0;

    vt[0]  = '{32'd100,       32'd7,         1'b0, 1'b0, 32'd14};
    vt[1]  = '{32'd100,       32'd7,         1'b0, 1'b1, 32'd2};
    vt[2]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, 32'hFFFF_FFFD};
    vt[3]  = '{32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1, 32'hFFFF_FFFF};
    vt[4]  = '{32'h8000_0005, 32'd0,         1'b1, 1'b0, 32'hFFFF_FFFF};
    vt[5]  = '{32'h8000_0005, 32'd0,         1'b1, 1'b1, 32'h8000_0005};
    vt[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000};
    vt[7]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0};
    vt[8]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0};
    vt[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000};
    vt[10] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD};
    vt[11] = '{32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1, 32'd1};
    vt[12] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'd3};
    vt[13] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vt[14] = '{32'hFFFF_FFFF, 32'h10,        1'b0, 1'b0, 32'h0FFF_FFFF};
    vt[15] = '{32'd1234,      32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF};
    vt[16] = '{32'd1234,      32'd0,         1'b0, 1'b1, 32'd1234};
    vt[17] = '{32'd5,         32'd10,        1'b0, 1'b1, 32'd5};

    // Reset state, with a request already waiting for the first edge after release.
    resetn = 1'b0; flush = 1'b0; valid = 1'b1;
    rs1 = 32'd100; rs2 = 32'd7; op_signed = 1'b0; op_rem = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1 valid = 1'b0;
    check("first_accept_busy", {31'd0, busy}, 32'd1);
    wait_ready(lat);
    check("first_latency", lat, 34);
    check("first_result", result, 32'd14);

    foreach (vt[i]) begin
      run_op(vt[i].a, vt[i].b, vt[i].s, vt[i].r, res, lat);
      check($sformatf("vec%0d_latency", i), lat, 34);
      check($sformatf("vec%0d_result", i), res, vt[i].exp);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_ready_low", i), {31'd0, ready}, 32'd0);
      check($sformatf("vec%0d_result_hold", i), result, vt[i].exp);
    end
    last_res = vt[17].exp;

    // flush together with valid in IDLE: not accepted
    @(negedge clock);
    rs1 = 32'd50; rs2 = 32'd5; valid = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1 valid = 1'b0; flush = 1'b0;
    check("flush_valid_idle_busy", {31'd0, busy}, 32'd0);

    // valid during DONE must not start a new operation
    run_op(32'd50, 32'd5, 1'b0, 1'b0, res, lat);
    check("done_op_result", res, 32'd10);
    rs1 = 32'd77; rs2 = 32'd7; valid = 1'b1;
    @(posedge clock);
    #1 valid = 1'b0;
    @(negedge clock);
    check("valid_in_done_busy", {31'd0, busy}, 32'd0);
    last_res = 32'd10;

    // flush at RUN cycle 10, ignored valid pulse while busy, then 9/3
    r0 = rdy_cnt;
    @(negedge clock);
    rs1 = 32'd100; rs2 = 32'd7; op_signed = 1'b0; op_rem = 1'b0; valid = 1'b1;
    @(posedge clock);
    #1 valid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    rs1 = 32'd9; rs2 = 32'd3; valid = 1'b1;
    @(posedge clock);
    #1 valid = 1'b0;
    check("busy_during_run", {31'd0, busy}, 32'd1);
    repeat (5) @(posedge clock);
    @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_result_kept", result, last_res);
    @(negedge clock);
    @(negedge clock);
    rs1 = 32'd9; rs2 = 32'd3; valid = 1'b1;
    @(posedge clock);
    #1 valid = 1'b0;
    wait_ready(lat);
    check("post_flush_latency", lat, 34);
    check("post_flush_result", result, 32'd3);
    repeat (40) @(posedge clock);
    check("flush_ready_count", rdy_cnt - r0, 1);

    // asynchronous reset mid-operation
    @(negedge clock);
    rs1 = 32'd1000; rs2 = 32'd3; valid = 1'b1;
    @(posedge clock);
    #1 valid = 1'b0;
    repeat (15) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_result", result, 32'd0);
    r0 = rdy_cnt;
    @(negedge clock);
    resetn = 1'b1;
    repeat (40) @(posedge clock);
    check("midreset_no_ready", rdy_cnt - r0, 0);

    // randomised operations against the arithmetic model
    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
      s = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      run_op(a, b, s, r, res, lat);
      check($sformatf("rand%0d_latency", k), lat, 34);
      check($sformatf("rand%0d_result a=%h b=%h s=%0d r=%0d", k, a, b, s, r), res, model(a, b, s, r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
